// File: rtl/verification_chain_display.sv
// ============================================================================
// Module      : verification_chain_display
// Description : Rasterises a chain of alternating connection/process
//               rectangles and emits one VGA pixel per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module verification_chain_display #(
    parameter int NUM_STAGES = 7,
    parameter int CONN_W     = 32,
    parameter int CONN_H     = 2,
    parameter int PROC_W     = 16,
    parameter int PROC_H     = 32,
    parameter int STEP_X     = 16,
    parameter int PROC_Y_OFF = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       abort,
    input  logic       erase,
    input  logic [8:0] start_x,
    input  logic [7:0] start_y,
    input  logic [2:0] conn_colour,
    input  logic [2:0] proc_colour,
    input  logic [2:0] bg_colour,
    output logic [8:0] x_coord,
    output logic [7:0] y_coord,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done_drawing,
    output logic [3:0] stage
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [8:0] CW_M1      = 9'(CONN_W - 1);
    localparam logic [8:0] PW_M1      = 9'(PROC_W - 1);
    localparam logic [7:0] CH_M1      = 8'(CONN_H - 1);
    localparam logic [7:0] PH_M1      = 8'(PROC_H - 1);
    localparam logic [3:0] LAST_STAGE = 4'(NUM_STAGES - 1);
    localparam logic [7:0] Y_OFF      = 8'(PROC_Y_OFF);

    logic [1:0] state;
    // Counters track the pixel currently presented on the outputs.
    logic [3:0] cur_stage;
    logic [8:0] x_off;
    logic [7:0] y_off;

    logic [8:0] sx_l;
    logic [7:0] sy_l;
    logic       erase_l;
    logic [2:0] cc_l;
    logic [2:0] pc_l;
    logic [2:0] bc_l;

    logic       last_x;
    logic       last_y;
    logic       last_pixel;
    logic [3:0] nxt_stage;
    logic [8:0] nxt_xo;
    logic [7:0] nxt_yo;

    always_comb begin
        last_x     = (x_off == (cur_stage[0] ? PW_M1 : CW_M1));
        last_y     = (y_off == (cur_stage[0] ? PH_M1 : CH_M1));
        last_pixel = last_x && last_y && (cur_stage == LAST_STAGE);
        nxt_stage  = cur_stage;
        nxt_xo     = x_off + 9'd1;
        nxt_yo     = y_off;
        if (last_x) begin
            nxt_xo = 9'd0;
            nxt_yo = y_off + 8'd1;
            if (last_y) begin
                nxt_yo    = 8'd0;
                nxt_stage = cur_stage + 4'd1;
            end
        end
    end

    // The first pixel is computed straight from the start inputs so it can be
    // registered on the start edge itself.
    logic       idle_src;
    logic [3:0] src_stage;
    logic [8:0] src_xo;
    logic [7:0] src_yo;
    logic [8:0] src_sx;
    logic [7:0] src_sy;
    logic       src_erase;
    logic [2:0] src_cc;
    logic [2:0] src_pc;
    logic [2:0] src_bc;
    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic [2:0] pix_col;
    logic       pix_plot;

    always_comb begin
        idle_src  = (state == S_IDLE);
        src_stage = idle_src ? 4'd0        : nxt_stage;
        src_xo    = idle_src ? 9'd0        : nxt_xo;
        src_yo    = idle_src ? 8'd0        : nxt_yo;
        src_sx    = idle_src ? start_x     : sx_l;
        src_sy    = idle_src ? start_y     : sy_l;
        src_erase = idle_src ? erase       : erase_l;
        src_cc    = idle_src ? conn_colour : cc_l;
        src_pc    = idle_src ? proc_colour : pc_l;
        src_bc    = idle_src ? bg_colour   : bc_l;
        pix_x     = src_sx + 9'(int'(src_stage) * STEP_X) + src_xo;
        pix_y     = src_sy - (src_stage[0] ? Y_OFF : 8'd0) + src_yo;
        pix_col   = src_erase ? src_bc : (src_stage[0] ? src_pc : src_cc);
        pix_plot  = (pix_x < 9'd320) && (pix_y < 8'd240);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            cur_stage    <= 4'd0;
            x_off        <= 9'd0;
            y_off        <= 8'd0;
            sx_l         <= 9'd0;
            sy_l         <= 8'd0;
            erase_l      <= 1'b0;
            cc_l         <= 3'd0;
            pc_l         <= 3'd0;
            bc_l         <= 3'd0;
            x_coord      <= 9'd0;
            y_coord      <= 8'd0;
            colour       <= 3'd0;
            plot         <= 1'b0;
            busy         <= 1'b0;
            done_drawing <= 1'b0;
            stage        <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_drawing <= 1'b0;
                    if (start) begin
                        state     <= S_DRAW;
                        sx_l      <= start_x;
                        sy_l      <= start_y;
                        erase_l   <= erase;
                        cc_l      <= conn_colour;
                        pc_l      <= proc_colour;
                        bc_l      <= bg_colour;
                        cur_stage <= 4'd0;
                        x_off     <= 9'd0;
                        y_off     <= 8'd0;
                        x_coord   <= pix_x;
                        y_coord   <= pix_y;
                        colour    <= pix_col;
                        plot      <= pix_plot;
                        busy      <= 1'b1;
                        stage     <= 4'd0;
                    end
                end
                S_DRAW: begin
                    if (abort || last_pixel) begin
                        state        <= abort ? S_IDLE : S_DONE;
                        done_drawing <= !abort;
                        cur_stage    <= 4'd0;
                        x_off        <= 9'd0;
                        y_off        <= 8'd0;
                        x_coord      <= 9'd0;
                        y_coord      <= 8'd0;
                        colour       <= 3'd0;
                        plot         <= 1'b0;
                        busy         <= 1'b0;
                        stage        <= 4'd0;
                    end else begin
                        cur_stage <= nxt_stage;
                        x_off     <= nxt_xo;
                        y_off     <= nxt_yo;
                        x_coord   <= pix_x;
                        y_coord   <= pix_y;
                        colour    <= pix_col;
                        plot      <= pix_plot;
                        stage     <= nxt_stage;
                    end
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    done_drawing <= 1'b0;
                end
                default: begin
                    state        <= S_IDLE;
                    done_drawing <= 1'b0;
                    plot         <= 1'b0;
                    busy         <= 1'b0;
                    stage        <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
